pc_gen: RTL and testbench



---
 rtl/pc_gen.sv | 141 ++++++++++++++
 tb/tb_pc_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program-counter generator: reset/boot bubble, sequential fetch, redirect, exception entry/return with EPC.
// Latency: every update is visible one clock after it is sampled; all state is held in flops.
// Backpressure: stall or !fetch_ready holds pc; redirect/exception/eret act regardless. Optional macro: PC_ALIGN_CHECK_EN.
module pc_gen #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR  = 'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VECTOR  = 'h0000_4180,
    parameter int               INSTR_BYTES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             exc_req,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic [WIDTH-1:0] epc,
    output logic             exl,
    output logic [WIDTH-1:0] bad_addr
);

    localparam int               ALIGN_BITS = $clog2(INSTR_BYTES);
    localparam logic [WIDTH-1:0] LOW_MASK   = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);
    localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSTR_BYTES);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        HANDLER = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] aligned_target;
    logic             advance;

    assign aligned_target = redirect_target & ~LOW_MASK;
    assign advance        = !stall && fetch_ready;

`ifdef PC_ALIGN_CHECK_EN
    logic [WIDTH-1:0] bad_q, bad_d;
    logic             misaligned;

    assign misaligned = (redirect_target & LOW_MASK) != '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_ADDR;
            epc_q   <= '0;
`ifdef PC_ALIGN_CHECK_EN
            bad_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
`ifdef PC_ALIGN_CHECK_EN
            bad_q   <= bad_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
`ifdef PC_ALIGN_CHECK_EN
        bad_d   = bad_q;
`endif
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                // An exception beats a same-cycle redirect; epc keeps the current pc.
                if (exc_req) begin
                    epc_d   = pc_q;
                    pc_d    = EXC_VECTOR;
                    state_d = HANDLER;
                end else if (redirect_valid) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (misaligned) begin
                        bad_d   = redirect_target;
                        epc_d   = pc_q;
                        pc_d    = EXC_VECTOR;
                        state_d = HANDLER;
                    end else begin
                        pc_d = aligned_target;
                    end
`else
                    pc_d = aligned_target;
`endif
                end else if (advance) begin
                    pc_d = pc_q + STEP;
                end
            end
            HANDLER: begin
                if (eret) begin
                    pc_d    = epc_q;
                    state_d = RUN;
                end else if (redirect_valid) begin
                    pc_d = aligned_target;
`ifdef PC_ALIGN_CHECK_EN
                    if (misaligned) begin
                        bad_d = redirect_target;
                    end
`endif
                end else if (advance) begin
                    pc_d = pc_q + STEP;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        pc_valid = 1'b0;
        exl      = 1'b0;
        case (state_q)
            RUN:     pc_valid = 1'b1;
            HANDLER: begin
                pc_valid = 1'b1;
                exl      = 1'b1;
            end
            default: pc_valid = 1'b0;
        endcase
    end

    assign pc  = pc_q;
    assign epc = epc_q;
`ifdef PC_ALIGN_CHECK_EN
    assign bad_addr = bad_q;
`else
    assign bad_addr = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: vector table plus a randomised stall/handshake sequence, checked through a scoreboard queue.
module tb_pc_gen;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] epc;
    logic        exl;
    logic [31:0] bad_addr;

    pc_gen dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .fetch_ready     (fetch_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_req         (exc_req),
        .eret            (eret),
        .pc              (pc),
        .pc_valid        (pc_valid),
        .epc             (epc),
        .exl             (exl),
        .bad_addr        (bad_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic        vld;
        logic [31:0] epc;
        logic        exl;
        logic [31:0] bad;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        fr;
        logic        rv;
        logic [31:0] tgt;
        logic        exc;
        logic        ert;
        exp_t        exp;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic rst, input logic stl, input logic fr, input logic rv,
                       input logic [31:0] tgt, input logic exc, input logic ert,
                       input logic [31:0] e_pc, input logic e_vld, input logic [31:0] e_epc,
                       input logic e_exl, input logic [31:0] e_bad);
        vec_t v;
        v.rst = rst; v.stl = stl; v.fr = fr; v.rv = rv; v.tgt = tgt; v.exc = exc; v.ert = ert;
        v.exp.pc = e_pc; v.exp.vld = e_vld; v.exp.epc = e_epc; v.exp.exl = e_exl; v.exp.bad = e_bad;
        vecs.push_back(v);
    endtask

    task automatic cmp32(input string tag, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL step %0d %s: got %h expected %h", idx, tag, act, req);
        end
    endtask

    task automatic check_outputs(input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL step %0d scoreboard: got empty queue expected an entry", idx);
        end else begin
            e = sb.pop_front();
            cmp32("pc",       idx, pc,              e.pc);
            cmp32("pc_valid", idx, {31'd0, pc_valid}, {31'd0, e.vld});
            cmp32("epc",      idx, epc,             e.epc);
            cmp32("exl",      idx, {31'd0, exl},    {31'd0, e.exl});
            cmp32("bad_addr", idx, bad_addr,        e.bad);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, then compare just after the edge.
    task automatic step(input vec_t v, input int idx);
        reset           = v.rst;
        stall           = v.stl;
        fetch_ready     = v.fr;
        redirect_valid  = v.rv;
        redirect_target = v.tgt;
        exc_req         = v.exc;
        eret            = v.ert;
        sb.push_back(v.exp);
        @(posedge clock);
        #1;
        check_outputs(idx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] bb;
        logic [31:0] e0;
        logic [31:0] e_pc;
        vec_t        v;

        reset = 1'b1; stall = 1'b0; fetch_ready = 1'b1; redirect_valid = 1'b0;
        redirect_target = '0; exc_req = 1'b0; eret = 1'b0;
        #1;

        //  rst stl fr rv target        exc ert  pc            vld epc           exl bad
        add(1, 0, 1, 0, 32'h0,         0, 0, 32'h0000_3000, 0, 32'h0,        0, 32'h0);
        add(1, 0, 1, 0, 32'h0,         0, 0, 32'h0000_3000, 0, 32'h0,        0, 32'h0);
        add(0, 0, 1, 0, 32'h0,         0, 0, 32'h0000_3000, 1, 32'h0,        0, 32'h0);
        add(0, 0, 1, 0, 32'h0,         0, 0, 32'h0000_3004, 1, 32'h0,        0, 32'h0);
        add(0, 0, 1, 0, 32'h0,         0, 0, 32'h0000_3008, 1, 32'h0,        0, 32'h0);
        for (int i = 0; i < 3; i++)
            add(0, 1, 1, 0, 32'h0,     0, 0, 32'h0000_3008, 1, 32'h0,        0, 32'h0);
        for (int i = 0; i < 2; i++)
            add(0, 0, 0, 0, 32'h0,     0, 0, 32'h0000_3008, 1, 32'h0,        0, 32'h0);
        add(0, 0, 1, 0, 32'h0,         0, 0, 32'h0000_300C, 1, 32'h0,        0, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        bb = 32'h0000_5002;
        e0 = 32'h0000_300C;
        add(0, 1, 1, 1, 32'h0000_5002, 0, 0, 32'h0000_4180, 1, e0,           1, bb);
        add(0, 0, 1, 0, 32'h0,         0, 1, 32'h0000_300C, 1, e0,           0, bb);
        add(0, 0, 1, 1, 32'h0000_3010, 0, 0, 32'h0000_3010, 1, e0,           0, bb);
`else
        bb = 32'h0;
        e0 = 32'h0;
        add(0, 1, 1, 1, 32'h0000_5002, 0, 0, 32'h0000_5000, 1, e0,           0, bb);
        add(0, 0, 1, 1, 32'h0000_3010, 0, 0, 32'h0000_3010, 1, e0,           0, bb);
`endif
        add(0, 0, 1, 1, 32'h0000_6000, 1, 0, 32'h0000_4180, 1, 32'h0000_3010, 1, bb);
        add(0, 0, 1, 0, 32'h0,         1, 0, 32'h0000_4184, 1, 32'h0000_3010, 1, bb);
        add(0, 0, 1, 0, 32'h0,         0, 1, 32'h0000_3010, 1, 32'h0000_3010, 0, bb);
        add(0, 0, 1, 0, 32'h0,         0, 0, 32'h0000_3014, 1, 32'h0000_3010, 0, bb);
        add(0, 1, 0, 0, 32'h0,         1, 0, 32'h0000_4180, 1, 32'h0000_3014, 1, bb);
        add(0, 0, 1, 0, 32'h0,         1, 1, 32'h0000_3014, 1, 32'h0000_3014, 0, bb);
        add(0, 0, 1, 0, 32'h0,         0, 1, 32'h0000_3018, 1, 32'h0000_3014, 0, bb);
        add(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 32'h0000_3014, 0, bb);
        add(0, 0, 1, 0, 32'h0,         0, 0, 32'h0000_0000, 1, 32'h0000_3014, 0, bb);
        add(0, 0, 1, 0, 32'h0,         0, 0, 32'h0000_0004, 1, 32'h0000_3014, 0, bb);
        add(1, 0, 1, 1, 32'h0000_7000, 1, 0, 32'h0000_3000, 0, 32'h0,        0, 32'h0);
        add(0, 0, 1, 0, 32'h0,         1, 0, 32'h0000_3000, 1, 32'h0,        0, 32'h0);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], i);

        // Random stall/handshake mix in RUN: pc advances only when !stall && fetch_ready.
        e_pc = 32'h0000_3000;
        for (int i = 0; i < 24; i++) begin
            v.rst = 1'b0; v.rv = 1'b0; v.tgt = '0; v.exc = 1'b0; v.ert = 1'b0;
            v.stl = 1'($urandom_range(0, 1));
            v.fr  = 1'($urandom_range(0, 1));
            if (!v.stl && v.fr)
                e_pc = e_pc + 32'd4;
            v.exp.pc = e_pc; v.exp.vld = 1'b1; v.exp.epc = 32'h0; v.exp.exl = 1'b0; v.exp.bad = 32'h0;
            step(v, 1000 + i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
